// File: rtl/mem_stage_if.sv
// Data-memory port bundle between the MEM stage (master) and the data memory (slave).
// The memory answers with dmem_ready, and dmem_rdata is valid in that same cycle.
interface mem_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_byte_en;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_byte_en,
      input  dmem_ready, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_byte_en,
      output dmem_ready, dmem_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// veriRISCV memory-access stage: issues aligned loads/stores, formats load data,
// flags misaligned accesses, stalls upstream while busy and drives the MEM/WB pipe.
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ex2mem_pc,
   input  logic [31:0] ex2mem_instruction,
   input  logic        ex2mem_reg_wen,
   input  logic [4:0]  ex2mem_reg_waddr,
   input  logic [31:0] ex2mem_alu_out,
   input  logic        ex2mem_mem_rd,
   input  logic        ex2mem_mem_wr,
   input  logic [1:0]  ex2mem_mem_size,
   input  logic        ex2mem_mem_unsigned,
   input  logic [31:0] ex2mem_mem_wdata,
   input  logic        ex2mem_csr_rd,
   input  logic [1:0]  ex2mem_csr_wr_op,
   input  logic [31:0] ex2mem_csr_wdata,
   input  logic [11:0] ex2mem_csr_addr,
   input  logic        ex2mem_sel_csr,
   input  logic        ex2mem_ill_instr,
   input  logic        ex2mem_exc_instr_addr_misaligned,
   mem_stage_if.master dmem,
   output logic        mem_stall,
   output logic [31:0] mem2wb_pc,
   output logic [31:0] mem2wb_instruction,
   output logic        mem2wb_reg_wen,
   output logic [4:0]  mem2wb_reg_waddr,
   output logic [31:0] mem2wb_reg_wdata,
   output logic        mem2wb_csr_rd,
   output logic [1:0]  mem2wb_csr_wr_op,
   output logic [31:0] mem2wb_csr_wdata,
   output logic [11:0] mem2wb_csr_addr,
   output logic        mem2wb_sel_csr,
   output logic        mem2wb_ill_instr,
   output logic        mem2wb_exc_instr_addr_misaligned,
   output logic        mem2wb_exc_load_addr_misaligned,
   output logic        mem2wb_exc_store_addr_misaligned
);

   localparam int DATA_W     = 32;
   localparam int PC_W       = 32;
   localparam int RF_W       = 5;
   localparam int CSR_OP_W   = 2;
   localparam int CSR_ADDR_W = 12;

   typedef enum logic {IDLE, BUSY} state_t;

   typedef struct packed {
      logic [PC_W-1:0]       pc;
      logic [31:0]           instruction;
      logic                  reg_wen;
      logic [RF_W-1:0]       reg_waddr;
      logic [DATA_W-1:0]     reg_wdata;
      logic                  csr_rd;
      logic [CSR_OP_W-1:0]   csr_wr_op;
      logic [DATA_W-1:0]     csr_wdata;
      logic [CSR_ADDR_W-1:0] csr_addr;
      logic                  sel_csr;
      logic                  ill_instr;
      logic                  exc_instr_addr_misaligned;
      logic                  exc_load_addr_misaligned;
      logic                  exc_store_addr_misaligned;
   } wb_t;

   function automatic logic [3:0] lane_en(input logic [1:0] sz, input logic [1:0] off);
      case (sz)
         2'd0:    return 4'b0001 << off;
         2'd1:    return 4'b0011 << {off[1], 1'b0};
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] store_data(input logic [1:0] sz, input logic [DATA_W-1:0] wd);
      case (sz)
         2'd0:    return {4{wd[7:0]}};
         2'd1:    return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] fmt_load(input logic [DATA_W-1:0] rdata, input logic [1:0] sz,
                                                  input logic [1:0] off, input logic uns);
      logic signed [7:0]        b;
      logic signed [15:0]       h;
      logic signed [DATA_W-1:0] r;
      b = rdata[{off, 3'b000} +: 8];
      h = off[1] ? rdata[31:16] : rdata[15:0];
      case (sz)
         2'd0: begin
            if (uns) r = {24'h0, b};
            else     r = b;
         end
         2'd1: begin
            if (uns) r = {16'h0, h};
            else     r = h;
         end
         default: r = rdata;
      endcase
      return r;
   endfunction

   state_t            state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [31:0]       addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   wb_t               wb_q, wb_d, wb_in;

   logic access, misaligned, aligned_access;

   assign access     = ex2mem_mem_rd | ex2mem_mem_wr;
   // Size 3 is not a legal encoding; it is treated as a word for alignment.
   assign misaligned = access &
                       (((ex2mem_mem_size == 2'd1) & ex2mem_alu_out[0]) |
                        (ex2mem_mem_size[1] & (ex2mem_alu_out[1:0] != 2'b00)));
   assign aligned_access = access & ~misaligned;

   always_comb begin
      wb_in                           = '0;
      wb_in.pc                        = ex2mem_pc;
      wb_in.instruction               = ex2mem_instruction;
      wb_in.reg_wen                   = ex2mem_reg_wen;
      wb_in.reg_waddr                 = ex2mem_reg_waddr;
      wb_in.reg_wdata                 = ex2mem_alu_out;
      wb_in.csr_rd                    = ex2mem_csr_rd;
      wb_in.csr_wr_op                 = ex2mem_csr_wr_op;
      wb_in.csr_wdata                 = ex2mem_csr_wdata;
      wb_in.csr_addr                  = ex2mem_csr_addr;
      wb_in.sel_csr                   = ex2mem_sel_csr;
      wb_in.ill_instr                 = ex2mem_ill_instr;
      wb_in.exc_instr_addr_misaligned = ex2mem_exc_instr_addr_misaligned;
   end

   // EX/MEM fields are held upstream during the stall, so BUSY reads them directly.
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      wb_d      = '0;
      mem_stall = 1'b0;
      case (state_q)
         IDLE: begin
            if (aligned_access) begin
               mem_stall = 1'b1;
               req_d     = 1'b1;
               we_d      = ~ex2mem_mem_rd;
               addr_d    = {ex2mem_alu_out[31:2], 2'b00};
               wdata_d   = store_data(ex2mem_mem_size, ex2mem_mem_wdata);
               be_d      = lane_en(ex2mem_mem_size, ex2mem_alu_out[1:0]);
               state_d   = BUSY;
            end else begin
               wb_d = wb_in;
               if (misaligned) begin
                  wb_d.reg_wen                   = 1'b0;
                  wb_d.exc_load_addr_misaligned  = ex2mem_mem_rd;
                  wb_d.exc_store_addr_misaligned = ~ex2mem_mem_rd;
               end
            end
         end
         BUSY: begin
            if (dmem.dmem_ready) begin
               req_d   = 1'b0;
               state_d = IDLE;
               wb_d    = wb_in;
               if (ex2mem_mem_rd)
                  wb_d.reg_wdata = fmt_load(dmem.dmem_rdata, ex2mem_mem_size,
                                            ex2mem_alu_out[1:0], ex2mem_mem_unsigned);
            end else begin
               mem_stall = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---- MEM/WB and data-port register boundary ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         wb_q    <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         wb_q    <= wb_d;
      end
   end

   assign dmem.dmem_req     = req_q;
   assign dmem.dmem_we      = we_q;
   assign dmem.dmem_addr    = addr_q;
   assign dmem.dmem_wdata   = wdata_q;
   assign dmem.dmem_byte_en = be_q;

   assign mem2wb_pc                        = wb_q.pc;
   assign mem2wb_instruction               = wb_q.instruction;
   assign mem2wb_reg_wen                   = wb_q.reg_wen;
   assign mem2wb_reg_waddr                 = wb_q.reg_waddr;
   assign mem2wb_reg_wdata                 = wb_q.reg_wdata;
   assign mem2wb_csr_rd                    = wb_q.csr_rd;
   assign mem2wb_csr_wr_op                 = wb_q.csr_wr_op;
   assign mem2wb_csr_wdata                 = wb_q.csr_wdata;
   assign mem2wb_csr_addr                  = wb_q.csr_addr;
   assign mem2wb_sel_csr                   = wb_q.sel_csr;
   assign mem2wb_ill_instr                 = wb_q.ill_instr;
   assign mem2wb_exc_instr_addr_misaligned = wb_q.exc_instr_addr_misaligned;
   assign mem2wb_exc_load_addr_misaligned  = wb_q.exc_load_addr_misaligned;
   assign mem2wb_exc_store_addr_misaligned = wb_q.exc_store_addr_misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed test-plan cases followed by random transactions,
// checked against an arithmetic reference model of the load/store rules.
module tb_mem_stage;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [31:0] e_pc, e_instr, e_alu, e_wd, e_csr_wdata;
   logic        e_wen, e_rd, e_wr, e_uns, e_csr_rd, e_sel_csr, e_ill, e_iam;
   logic [4:0]  e_waddr;
   logic [1:0]  e_size, e_csr_op;
   logic [11:0] e_csr_addr;

   logic        stall;
   logic [31:0] w_pc, w_instr, w_wdata, w_csr_wdata;
   logic        w_wen, w_csr_rd, w_sel_csr, w_ill, w_iam, w_lam, w_sam;
   logic [4:0]  w_waddr;
   logic [1:0]  w_csr_op;
   logic [11:0] w_csr_addr;

   mem_stage_if dif();

   mem_stage dut (
      .clk(clk), .rst(rst),
      .ex2mem_pc(e_pc), .ex2mem_instruction(e_instr), .ex2mem_reg_wen(e_wen),
      .ex2mem_reg_waddr(e_waddr), .ex2mem_alu_out(e_alu), .ex2mem_mem_rd(e_rd),
      .ex2mem_mem_wr(e_wr), .ex2mem_mem_size(e_size), .ex2mem_mem_unsigned(e_uns),
      .ex2mem_mem_wdata(e_wd), .ex2mem_csr_rd(e_csr_rd), .ex2mem_csr_wr_op(e_csr_op),
      .ex2mem_csr_wdata(e_csr_wdata), .ex2mem_csr_addr(e_csr_addr), .ex2mem_sel_csr(e_sel_csr),
      .ex2mem_ill_instr(e_ill), .ex2mem_exc_instr_addr_misaligned(e_iam),
      .dmem(dif),
      .mem_stall(stall),
      .mem2wb_pc(w_pc), .mem2wb_instruction(w_instr), .mem2wb_reg_wen(w_wen),
      .mem2wb_reg_waddr(w_waddr), .mem2wb_reg_wdata(w_wdata), .mem2wb_csr_rd(w_csr_rd),
      .mem2wb_csr_wr_op(w_csr_op), .mem2wb_csr_wdata(w_csr_wdata), .mem2wb_csr_addr(w_csr_addr),
      .mem2wb_sel_csr(w_sel_csr), .mem2wb_ill_instr(w_ill),
      .mem2wb_exc_instr_addr_misaligned(w_iam),
      .mem2wb_exc_load_addr_misaligned(w_lam),
      .mem2wb_exc_store_addr_misaligned(w_sam)
   );

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed = passed + 1;
      end else begin
         fails = fails + 1;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference model: plain arithmetic on byte offsets.
   function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [31:0] addr,
                                            input int sz, input logic uns);
      longint v;
      int     off;
      off = int'(addr % 4);
      if (sz == 0) begin
         v = (longint'(word) >> (8 * off)) % 256;
         if (!uns && v >= 128) v = v - 256;
      end else if (sz == 1) begin
         v = (longint'(word) >> (16 * (off / 2))) % 65536;
         if (!uns && v >= 32768) v = v - 65536;
      end else begin
         v = longint'(word);
      end
      return v[31:0];
   endfunction

   function automatic logic [31:0] exp_be(input int sz, input logic [31:0] addr);
      int off;
      off = int'(addr % 4);
      if (sz == 0) return 32'(1 << off);
      if (sz == 1) return 32'(3 << ((off / 2) * 2));
      return 32'd15;
   endfunction

   function automatic logic [31:0] exp_sd(input int sz, input logic [31:0] wd);
      if (sz == 0) return (wd % 256) * 32'h0101_0101;
      if (sz == 1) return (wd % 65536) * 32'h0001_0001;
      return wd;
   endfunction

   task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
      e_rd = ld; e_wr = st; e_size = sz; e_uns = uns; e_alu = addr; e_wd = wd;
      e_pc = $urandom; e_instr = $urandom; e_waddr = 5'($urandom);
      e_wen = (st && !ld) ? 1'b0 : 1'b1;
      e_csr_rd = 1'($urandom); e_csr_op = 2'($urandom); e_csr_wdata = $urandom;
      e_csr_addr = 12'($urandom); e_sel_csr = 1'($urandom); e_ill = 1'($urandom);
      e_iam = 1'($urandom);
   endtask

   task automatic txn(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] word,
                      input int lat);
      logic acc, mis;
      int   isz;
      isz = int'(sz);
      drive(ld, st, sz, uns, addr, wd);
      dif.dmem_ready = 1'($urandom);
      dif.dmem_rdata = $urandom;
      acc = ld | st;
      mis = acc && ((isz == 1 && addr % 2 != 0) || (isz >= 2 && addr % 4 != 0));
      #1;
      if (!acc || mis) begin
         chk("stall_idle", stall, 0);
         tick;
         chk("req_idle", dif.dmem_req, 0);
         chk("wb_wen", w_wen, mis ? 1'b0 : e_wen);
         chk("wb_wdata", w_wdata, addr);
         chk("wb_pc", w_pc, e_pc);
         chk("exc_load", w_lam, mis && ld);
         chk("exc_store", w_sam, mis && !ld);
      end else begin
         chk("stall_issue", stall, 1);
         tick;
         chk("req_set", dif.dmem_req, 1);
         chk("dmem_addr", dif.dmem_addr, addr & 32'hFFFF_FFFC);
         chk("dmem_we", dif.dmem_we, !ld);
         if (!ld) begin
            chk("byte_en", dif.dmem_byte_en, exp_be(isz, addr));
            chk("dmem_wdata", dif.dmem_wdata, exp_sd(isz, wd));
         end
         chk("bubble_wen", w_wen, 0);
         for (int k = 1; k <= lat; k++) begin
            dif.dmem_ready = (k == lat);
            dif.dmem_rdata = (k == lat) ? word : $urandom;
            #1;
            chk("stall_busy", stall, k != lat);
            chk("req_hold", dif.dmem_req, 1);
            tick;
            dif.dmem_ready = 1'b0;
         end
         chk("req_drop", dif.dmem_req, 0);
         chk("wb_wen", w_wen, e_wen);
         chk("wb_wdata", w_wdata, ld ? exp_load(word, addr, isz, uns) : addr);
         chk("wb_pc", w_pc, e_pc);
         chk("wb_csr_wdata", w_csr_wdata, e_csr_wdata);
         chk("exc_clear", {30'd0, w_lam, w_sam}, 0);
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      dif.dmem_ready = 1'b0;
      dif.dmem_rdata = 32'h0;
      #12;
      chk("rst_req", dif.dmem_req, 0);
      chk("rst_addr", dif.dmem_addr, 0);
      chk("rst_wdata", dif.dmem_wdata, 0);
      chk("rst_be", dif.dmem_byte_en, 0);
      chk("rst_wb_pc", w_pc, 0);
      chk("rst_wb_wen", w_wen, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // ALU passthrough
      drive(0, 0, 0, 0, 32'h1234, 32'h0);
      e_waddr = 5'd5;
      e_wen = 1'b1;
      #1;
      chk("alu_stall", stall, 0);
      tick;
      chk("alu_wdata", w_wdata, 32'h1234);
      chk("alu_wen", w_wen, 1);
      chk("alu_waddr", w_waddr, 5);

      // LB / LBU at 0x103, three BUSY cycles
      txn(1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h80FF_FF7F, 3);
      chk("lb_signed", w_wdata, 32'hFFFF_FF80);
      txn(1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h80FF_FF7F, 3);
      chk("lbu", w_wdata, 32'h0000_0080);

      // SH at 0x202
      txn(0, 1, 2'd1, 0, 32'h202, 32'h0000_ABCD, 32'h0, 2);

      // Misaligned LW
      txn(1, 0, 2'd2, 0, 32'h101, 32'h0, 32'h0, 1);
      chk("lw_mis_flag", w_lam, 1);

      // Back-to-back SW then LW, ready in first BUSY cycle
      txn(0, 1, 2'd2, 0, 32'h300, 32'hDEAD_BEEF, 32'h0, 1);
      txn(1, 0, 2'd2, 0, 32'h304, 32'h0, 32'h1357_9BDF, 1);
      chk("lw_word", w_wdata, 32'h1357_9BDF);

      // Reset while BUSY
      drive(1, 0, 2'd2, 0, 32'h400, 32'h0);
      dif.dmem_ready = 1'b0;
      tick;
      chk("rb_req_before", dif.dmem_req, 1);
      #2 rst = 1'b1;
      #1;
      chk("rb_req_async", dif.dmem_req, 0);
      chk("rb_wb_pc", w_pc, 0);
      chk("rb_wb_instr", w_instr, 0);
      chk("rb_wb_csr", w_csr_wdata, 0);
      drive(0, 0, 0, 0, 32'h55, 32'h0);
      tick;
      rst = 1'b0;
      #1;
      chk("rb_idle_stall", stall, 0);
      chk("rb_req_after", dif.dmem_req, 0);
      chk("rb_wb_wen", w_wen, 0);

      // Random transactions
      for (int n = 0; n < 80; n++) begin
         int         kind;
         logic [1:0] sz;
         kind = $urandom_range(0, 3);
         sz   = 2'($urandom_range(0, 2));
         txn(kind == 1 || kind == 3, kind >= 2, sz, 1'($urandom), $urandom, $urandom,
             $urandom, $urandom_range(1, 4));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
